// File: rtl/fc_pkg.sv
// Shared definitions for the FC pass sequencer: state encoding and
// elaboration-time helpers for the derived layer constants.
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } fc_state_t;

   function automatic int unsigned fc_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Counter/select width; never narrower than one bit.
   function automatic int unsigned fc_width(input int unsigned n);
      return (n < 2) ? 1 : fc_clog2(n);
   endfunction

   function automatic int unsigned fc_beats(input int unsigned inneuron);
      return inneuron / 2;
   endfunction

   function automatic int unsigned fc_half(input int unsigned inneuron, input int unsigned pi);
      return inneuron / (2 * pi);
   endfunction

   function automatic int unsigned fc_passes(input int unsigned outneuron, input int unsigned po);
      return outneuron / po;
   endfunction

endpackage

// File: rtl/fc_beat_counter.sv
// Beat, PI-lane and packed-word counters for one pass; they hold while not
// advanced and saturate on the last beat until explicitly cleared.
module fc_beat_counter
   import fc_pkg::*;
#(
   parameter int unsigned BEATS  = 4,
   parameter int unsigned PI     = 2,
   parameter int unsigned BEAT_W = 2,
   parameter int unsigned LANE_W = 1,
   parameter int unsigned J_W    = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   output logic [BEAT_W-1:0] beat,
   output logic [LANE_W-1:0] lane,
   output logic [J_W-1:0]    j,
   output logic              last_c
);

   assign last_c = (beat == BEAT_W'(BEATS - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beat <= '0;
         lane <= '0;
         j    <= '0;
      end else if (clear) begin
         beat <= '0;
         lane <= '0;
         j    <= '0;
      end else if (advance && !last_c) begin
         beat <= beat + BEAT_W'(1);
         // The packed word index moves on only when the lane select wraps.
         if (lane == LANE_W'(PI - 1)) begin
            lane <= '0;
            j    <= j + J_W'(1);
         end else begin
            lane <= lane + LANE_W'(1);
         end
      end
   end

endmodule

// File: rtl/fc_pass_sequencer.sv
// Sequences one fully-connected layer: per pass it streams input/weight reads,
// drives the MAC controls, drains the MAC pipeline and writes PO results back.
module fc_pass_sequencer
   import fc_pkg::*;
#(
   parameter int unsigned INNEURON   = 8,
   parameter int unsigned OUTNEURON  = 4,
   parameter int unsigned PI         = 2,
   parameter int unsigned PO         = 2,
   parameter int unsigned IN_ADDR_W  = 4,
   parameter int unsigned W_ADDR_W   = 6,
   parameter int unsigned OUT_ADDR_W = 4,
   parameter int unsigned MAC_LAT    = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stall,
   output logic                    busy,
   output logic                    done,
   output logic [IN_ADDR_W-1:0]    in_addra,
   output logic [IN_ADDR_W-1:0]    in_addrb,
   output logic                    in_rden,
   output logic [fc_width(PI)-1:0] lane_sel,
   output logic [W_ADDR_W-1:0]     w_addr,
   output logic                    w_rden,
   output logic                    enable_mult,
   output logic                    accum_sload,
   output logic                    clear_mult,
   output logic                    wr_en,
   output logic [OUT_ADDR_W-1:0]   wr_addr
);

   localparam int unsigned BEATS   = fc_beats(INNEURON);
   localparam int unsigned HALF    = fc_half(INNEURON, PI);
   localparam int unsigned PASSES  = fc_passes(OUTNEURON, PO);
   localparam int unsigned BEAT_W  = fc_width(BEATS);
   localparam int unsigned LANE_W  = fc_width(PI);
   localparam int unsigned J_W     = fc_width(HALF);
   localparam int unsigned PASS_W  = fc_width(PASSES);
   localparam int unsigned DRAIN_W = fc_width(MAC_LAT + 1);

   fc_state_t          state, state_nx;
   logic [PASS_W-1:0]  pass, pass_nx;
   logic [DRAIN_W-1:0] drain, drain_nx;
   logic               valid_d, first_d;
   logic [BEAT_W-1:0]  beat;
   logic [LANE_W-1:0]  lane;
   logic [J_W-1:0]     j;
   logic               last_c, cnt_clear, cnt_adv;

   fc_beat_counter #(
      .BEATS (BEATS),
      .PI    (PI),
      .BEAT_W(BEAT_W),
      .LANE_W(LANE_W),
      .J_W   (J_W)
   ) u_beat (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .advance(cnt_adv),
      .beat   (beat),
      .lane   (lane),
      .j      (j),
      .last_c (last_c)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         pass  <= '0;
         drain <= '0;
      end else begin
         state <= state_nx;
         pass  <= pass_nx;
         drain <= drain_nx;
      end
   end

   // Beat-valid stage lines up with the 1-cycle RAM read; stall freezes it with the RAM q.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_d  <= 1'b0;
         first_d  <= 1'b0;
         lane_sel <= '0;
      end else if (!stall) begin
         valid_d  <= (state == ST_RUN);
         first_d  <= (beat == '0);
         lane_sel <= lane;
      end
   end

   always_comb begin
      state_nx    = state;
      pass_nx     = pass;
      drain_nx    = drain;
      cnt_clear   = 1'b0;
      cnt_adv     = 1'b0;
      busy        = (state != ST_IDLE);
      done        = 1'b0;
      in_addra    = '0;
      in_addrb    = '0;
      in_rden     = 1'b0;
      w_addr      = '0;
      w_rden      = 1'b0;
      enable_mult = valid_d & ~stall;
      accum_sload = valid_d & first_d & ~stall;
      clear_mult  = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      case (state)
         ST_IDLE: begin
            clear_mult = 1'b1;
            if (start) begin
               state_nx  = ST_RUN;
               pass_nx   = '0;
               drain_nx  = '0;
               cnt_clear = 1'b1;
            end
         end
         ST_RUN: begin
            in_addra = IN_ADDR_W'(j);
            in_addrb = IN_ADDR_W'(j) + IN_ADDR_W'(HALF);
            w_addr   = W_ADDR_W'(pass) * W_ADDR_W'(BEATS) + W_ADDR_W'(beat);
            if (!stall) begin
               in_rden = 1'b1;
               w_rden  = 1'b1;
               cnt_adv = 1'b1;
               if (last_c) begin
                  state_nx = ST_DRAIN;
                  drain_nx = '0;
               end
            end
         end
         // First DRAIN cycle carries the last enable_mult; MAC_LAT more cycles follow.
         ST_DRAIN: begin
            if (!stall) begin
               if (drain == DRAIN_W'(MAC_LAT)) state_nx = ST_WRITE;
               else                            drain_nx = drain + DRAIN_W'(1);
            end
         end
         ST_WRITE: begin
            wr_addr = OUT_ADDR_W'(pass);
            if (!stall) begin
               wr_en = 1'b1;
               if (pass == PASS_W'(PASSES - 1)) begin
                  state_nx = ST_DONE;
               end else begin
                  pass_nx   = pass + PASS_W'(1);
                  cnt_clear = 1'b1;
                  state_nx  = ST_RUN;
               end
            end
         end
         ST_DONE: begin
            if (!stall) begin
               done     = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule
